// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter_pkg
// Purpose : Shared types and constants for the SPI bus arbiter. Holds the
//           arbiter state encoding, the default turnaround length, and the
//           bundled per-host SPI signal struct with its idle value.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } spi_arb_state_e;

  localparam int SpiArbDefaultTurn = 2;

  typedef struct packed {
    logic sclk;
    logic copi;
    logic cs_n;
  } spi_host_t;

  // Value the bus is driven to whenever nobody owns it.
  localparam spi_host_t SpiHostIdle = '{sclk: 1'b0, copi: 1'b0, cs_n: 1'b1};

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin selector. Returns the first set bit of
//           req found when searching upward from ptr+1, wrapping modulo
//           NumReq. The pointer position itself is searched last.
// Ports   : req   in  NumReq  candidate request vector
//           ptr   in  IdxW    last winner (search starts just after it)
//           valid out 1       any request present
//           idx   out IdxW    winning index (holds ptr when none)
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);

  int                cand;
  logic [NumReq-1:0] shifted;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    valid   = 1'b0;
    idx     = ptr;
    cand    = 0;
    shifted = '0;
    for (int off = NumReq; off >= 1; off--) begin
      cand    = (int'(ptr) + off) % NumReq;
      shifted = req >> cand;
      if (shifted[0]) begin
        valid = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter
// Purpose : Shares one SPI bus between NumReq hosts. Round-robin arbitration
//           with a registered one-hot grant, and a forced-idle turnaround of
//           TurnCycles cycles (CS_N high) between owners.
//           Optional macro SPI_BUS_ARBITER_TIMEOUT_EN adds an owner hold
//           budget (MaxHold cycles) enforced only while others are waiting;
//           a revoked host is masked until it drops its request once.
// Ports   : clk_i, rst_i (async, active high)
//           req_i[NumReq]       per-host request level
//           gnt_o[NumReq]       one-hot grant
//           host_sclk_i/host_copi_i/host_cs_ni[NumReq]  host-side bus inputs
//           host_cipo_o[NumReq] CIPO routed back to the owner only
//           spi_sclk_o/spi_copi_o/spi_cs_no/spi_cipo_i  physical bus
//           busy_o              owned or in turnaround
//           owner_o             last/current owner index
//           timeout_o           one-cycle pulse on forced revocation
// Rev     : 1.0  initial release
// ============================================================================
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NumReq     = 2,
  parameter int TurnCycles = SpiArbDefaultTurn,
  parameter int MaxHold    = 1024,
  parameter int IdxW       = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  input  logic [NumReq-1:0] host_sclk_i,
  input  logic [NumReq-1:0] host_copi_i,
  input  logic [NumReq-1:0] host_cs_ni,
  output logic [NumReq-1:0] host_cipo_o,
  output logic              spi_sclk_o,
  output logic              spi_copi_o,
  output logic              spi_cs_no,
  input  logic              spi_cipo_i,
  output logic              busy_o,
  output logic [IdxW-1:0]   owner_o,
  output logic              timeout_o
);

  localparam logic [3:0] TurnInit = 4'(TurnCycles);

  spi_arb_state_e    state;
  logic [3:0]        turn_cnt;
  logic [NumReq-1:0] eligible;
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [NumReq-1:0] owner_oh;
  logic              owner_req;
  logic              revoke;
  spi_host_t         hosts [NumReq];
  spi_host_t         bus;

  assign owner_oh  = NumReq'(1) << owner_o;
  assign owner_req = |(req_i & owner_oh);

  for (genvar i = 0; i < NumReq; i++) begin : g_host
    assign hosts[i] = '{sclk: host_sclk_i[i], copi: host_copi_i[i], cs_n: host_cs_ni[i]};
  end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam int HoldW = $clog2(MaxHold + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MaxHold - 1);

  logic [HoldW-1:0]  hold_cnt;
  logic [NumReq-1:0] mask;
  logic              timeout_q;

  // Revoke only when the budget is spent and somebody else is waiting;
  // a voluntary release in the same cycle takes precedence.
  assign revoke   = (state == OWNED) && owner_req && (hold_cnt == HoldLast) &&
                    (|(req_i & ~owner_oh));
  assign eligible = req_i & ~mask;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt  <= '0;
      mask      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= revoke;
      // Zero outside OWNED, so the count restarts on every new tenure and
      // saturates once the budget is spent.
      if (state != OWNED) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HoldLast) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      // A masked host is released once its request has been seen low.
      mask <= (mask & req_i) | (revoke ? owner_oh : '0);
    end
  end

  assign timeout_o = timeout_q;
`else
  assign revoke    = 1'b0;
  assign eligible  = req_i;
  assign timeout_o = 1'b0;
`endif

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (owner_o),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      gnt_o    <= '0;
      owner_o  <= IdxW'(NumReq - 1);
      turn_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner_o <= pick_idx;
            gnt_o   <= NumReq'(1) << pick_idx;
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_req || revoke) begin
            gnt_o    <= '0;
            state    <= TURN;
            turn_cnt <= TurnInit;
          end
        end
        TURN: begin
          if (turn_cnt <= 4'd1) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  // Bus follows the owner combinationally; derived from the registered
  // state, so an async reset idles the bus immediately.
  always_comb begin
    bus         = SpiHostIdle;
    host_cipo_o = '0;
    if (state == OWNED) begin
      bus         = hosts[owner_o];
      host_cipo_o = owner_oh & {NumReq{spi_cipo_i}};
    end
  end

  assign spi_sclk_o = bus.sclk;
  assign spi_copi_o = bus.copi;
  assign spi_cs_no  = bus.cs_n;
  assign busy_o     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_bus_arbiter
// Purpose : Self-checking bench for spi_bus_arbiter (NumReq=3, TurnCycles=2,
//           MaxHold=16). Directed checks with literal expectations followed
//           by randomized requests/host activity compared every cycle
//           against a behavioural model of the arbitration rules.
//           Honours SPI_BUS_ARBITER_TIMEOUT_EN in the model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int N  = 3;
  localparam int TC = 2;
  localparam int MH = 16;
  localparam int IW = $clog2(N);
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  hs  = '0;
  logic [N-1:0]  hc  = '0;
  logic [N-1:0]  hcs = '1;
  logic          cipo = 1'b0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  hcipo;
  logic          sclk, copi, csn, busy, tmo;
  logic [IW-1:0] owner;

  spi_bus_arbiter #(.NumReq(N), .TurnCycles(TC), .MaxHold(MH), .IdxW(IW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .host_sclk_i (hs),
    .host_copi_i (hc),
    .host_cs_ni  (hcs),
    .host_cipo_o (hcipo),
    .spi_sclk_o  (sclk),
    .spi_copi_o  (copi),
    .spi_cs_no   (csn),
    .spi_cipo_i  (cipo),
    .busy_o      (busy),
    .owner_o     (owner),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_owned: someone holds the bus; m_turn: idle cycles still to serve
  // before arbitration may run; m_owner: last winner.
  bit m_owned;
  int m_turn, m_owner, m_hold;
  bit m_mask [N];
  bit m_tpulse;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owned = 0; m_turn = 0; m_owner = N - 1; m_hold = 0; m_tpulse = 0;
      for (int i = 0; i < N; i++) m_mask[i] = 0;
    end else begin
      bit others, rv;
      rv = 0;
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1;
      if (m_owned) begin
        if (!req[m_owner]) begin
          m_owned = 0; m_turn = TC;
        end else if (TO && (m_hold + 1 >= MH) && others) begin
          m_owned = 0; m_turn = TC; rv = 1;
        end else begin
          m_hold++;
        end
      end else if (m_turn > 0) begin
        m_turn--;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_owner + k) % N;
          if (!m_owned && req[c] && !m_mask[c]) begin
            m_owned = 1; m_owner = c; m_hold = 0;
          end
        end
      end
      for (int i = 0; i < N; i++) if (!req[i]) m_mask[i] = 0;
      if (rv) m_mask[m_owner] = 1;
      m_tpulse = rv;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    logic [N-1:0] eg, ec;
    logic es, eo, ecs, eb;
    eg  = m_owned ? (N'(1) << m_owner) : '0;
    es  = m_owned ? hs[m_owner]  : 1'b0;
    eo  = m_owned ? hc[m_owner]  : 1'b0;
    ecs = m_owned ? hcs[m_owner] : 1'b1;
    ec  = m_owned ? (N'(cipo) << m_owner) : '0;
    eb  = m_owned || (m_turn > 0);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sclk", 32'(sclk), 32'(es));
    chk("copi", 32'(copi), 32'(eo));
    chk("cs_n", 32'(csn), 32'(ecs));
    chk("host_cipo", 32'(hcipo), 32'(ec));
    chk("busy", 32'(busy), 32'(eb));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("timeout", 32'(tmo), 32'(m_tpulse));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus and literal checks ----------------
  initial begin
    int k;
    repeat (3) step();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_cs_n", 32'(csn), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'(N - 1));
    chk("rst_timeout", 32'(tmo), 32'h0);
    rst = 1'b0;
    step();

    // Single request: granted one cycle later, host 0 visible on the bus.
    req = 3'b001;
    step();
    chk("single_gnt", 32'(gnt), 32'h1);
    hs = 3'b001; hc = 3'b001; hcs = 3'b110; cipo = 1'b1;
    #1;
    chk("single_sclk", 32'(sclk), 32'h1);
    chk("single_copi", 32'(copi), 32'h1);
    chk("single_cs_n", 32'(csn), 32'h0);
    chk("single_cipo", 32'(hcipo), 32'h1);

    // Non-owner activity must not reach the bus.
    hs = 3'b010; hc = 3'b010; hcs = 3'b101;
    #1;
    chk("mask_sclk", 32'(sclk), 32'h0);
    chk("mask_cs_n", 32'(csn), 32'h1);
    chk("mask_cipo", 32'(hcipo), 32'h1);
    step();

    // Contention: host 1 waits, then gets the bus 1+TC+1 cycles after
    // host 0 drops its request.
    req = 3'b011;
    step();
    req = 3'b010;
    for (k = 1; k <= 12; k++) begin
      step();
      if (gnt == 3'b010) break;
      chk("turn_cs_n", 32'(csn), 32'h1);
    end
    chk("turn_latency", 32'(k), 32'd4);

    // Async reset mid-tenure idles the bus without waiting for a clock.
    hcs = 3'b000;
    #1;
    chk("owned_cs_n", 32'(csn), 32'h0);
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_cs_n", 32'(csn), 32'h1);
    chk("arst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;
    req = 3'b001;
    #1;
    chk("arst_owner", 32'(owner), 32'(N - 1));
    step();
    chk("arst_regrant", 32'(gnt), 32'h1);

    // Randomized phase: sticky requests so tenures last several cycles.
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      hs   = N'($urandom);
      hc   = N'($urandom);
      hcs  = N'($urandom);
      cipo = 1'($urandom);
      rst  = ($urandom_range(799) == 0);
    end
    rst = 1'b0;
    req = '0;
    repeat (8) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
